// File: rtl/ast_corner_collector.sv
// Merges per-lane nonmax-suppressed corner detections into one 32-bit ready/valid stream.
// Optional end-of-frame trailer word is enabled by defining CORNER_COLLECTOR_EOF_MARKER_EN.
module ast_corner_collector #(
    parameter int   LANES      = 4,
    parameter int   FIFO_DEPTH = 16,
    parameter int   MAX_QV     = 16383,
    parameter logic CAM_ADDR   = 1'b0,
    localparam int  LB         = $clog2(LANES)
) (
    input  logic                 c,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 fv,
    input  logic [LANES-1:0]     d_v,
    input  logic [8*LANES-1:0]   d_score,
    input  logic [10-LB:0]       d_col,
    input  logic [9:0]           d_row,
    input  logic                 d_invalid,
    output logic [31:0]          q,
    output logic                 qv,
    input  logic                 q_rdy,
    output logic [15:0]          qv_cnt,
    output logic [15:0]          drop_cnt,
    output logic                 frame_done
);

    localparam int LGW = (LB > 0) ? LB : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int PW  = AW + 1;
    localparam int EW  = 29;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACTIVE,
        S_DRAIN,
`ifdef CORNER_COLLECTOR_EOF_MARKER_EN
        S_TRAILER,
`endif
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic            fv_prev_q, fv_prev_d;
    logic            pending_q, pending_d;
    logic [LGW-1:0]  last_grant_q, last_grant_d;
    logic [31:0]     q_q, q_d;
    logic            qv_q, qv_d;
    logic            trl_q, trl_d;
    logic [15:0]     qv_cnt_q, qv_cnt_d;
    logic [15:0]     drop_cnt_q, drop_cnt_d;
    logic            frame_done_q, frame_done_d;
    logic [PW-1:0]   wr_ptr_q [LANES];
    logic [PW-1:0]   wr_ptr_d [LANES];
    logic [PW-1:0]   rd_ptr_q [LANES];
    logic [PW-1:0]   rd_ptr_d [LANES];
    logic [EW-1:0]   mem_q [LANES][FIFO_DEPTH];

    logic [EW-1:0]   lane_word [LANES];
    logic [LANES-1:0] empty, full, wr_try, wr_en;
    logic            all_empty, write_gate;
    logic [LGW-1:0]  cand, grant_idx;
    logic            grant_found, grant, out_free, fwd_ok, accept;
    logic [EW-1:0]   grant_word;
    logic [31:0]     drop_inc, drop_sum;
    logic            fv_rise, fv_fall;

    // FIFO status, write qualification and round-robin search from the lane after the last grant
    always_comb begin
        write_gate = (state_q == S_ACTIVE) & en & ~d_invalid;
        all_empty  = 1'b1;
        drop_inc   = '0;
        for (int i = 0; i < LANES; i++) begin
            empty[i]     = (wr_ptr_q[i] == rd_ptr_q[i]);
            full[i]      = ((wr_ptr_q[i] - rd_ptr_q[i]) == PW'(FIFO_DEPTH));
            wr_try[i]    = write_gate & d_v[i];
            wr_en[i]     = wr_try[i] & ~full[i];
            drop_inc     = drop_inc + 32'(wr_try[i] & full[i]);
            lane_word[i] = {11'((32'(d_col) << LB) | 32'(LANES - 1 - i)), d_row, d_score[8*i +: 8]};
            if (!empty[i]) begin
                all_empty = 1'b0;
            end
        end
        grant_found = 1'b0;
        grant_idx   = last_grant_q;
        cand        = '0;
        for (int k = 1; k <= LANES; k++) begin
            cand = LGW'((int'(last_grant_q) + k) % LANES);
            if (!grant_found && !empty[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
        out_free   = ~qv_q | q_rdy;
        grant      = grant_found & out_free;
        fwd_ok     = (32'(qv_cnt_q) + 32'(qv_q)) < 32'(MAX_QV);
        grant_word = mem_q[grant_idx][rd_ptr_q[grant_idx][AW-1:0]];
        if (grant && !fwd_ok) begin
            drop_inc = drop_inc + 32'd1;
        end
    end

    always_comb begin
        state_d      = state_q;
        fv_prev_d    = fv;
        pending_d    = pending_q;
        frame_done_d = 1'b0;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        last_grant_d = last_grant_q;
        q_d          = q_q;
        qv_d         = qv_q;
        trl_d        = trl_q;
        fv_rise      = fv & ~fv_prev_q;
        fv_fall      = ~fv & fv_prev_q;
        accept       = qv_q & q_rdy;
        qv_cnt_d     = qv_cnt_q + 16'(accept & ~trl_q);
        drop_sum     = 32'(drop_cnt_q) + drop_inc;
        drop_cnt_d   = (drop_sum > 32'h0000_FFFF) ? 16'hFFFF : drop_sum[15:0];

        for (int i = 0; i < LANES; i++) begin
            if (wr_en[i]) begin
                wr_ptr_d[i] = wr_ptr_q[i] + PW'(1);
            end
        end

        if (accept) begin
            qv_d  = 1'b0;
            trl_d = 1'b0;
        end

        // Capped grants still pop so stale detections drain instead of blocking the frame
        if (grant) begin
            rd_ptr_d[grant_idx] = rd_ptr_q[grant_idx] + PW'(1);
            last_grant_d        = grant_idx;
            if (fwd_ok) begin
                q_d   = {CAM_ADDR, 2'b00, grant_word};
                qv_d  = 1'b1;
                trl_d = 1'b0;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (fv_rise || pending_q) begin
                    state_d    = S_ACTIVE;
                    pending_d  = 1'b0;
                    qv_cnt_d   = '0;
                    drop_cnt_d = '0;
                end
            end
            S_ACTIVE: begin
                if (fv_fall) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (fv_rise) begin
                    pending_d = 1'b1;
                end
                if (all_empty) begin
`ifdef CORNER_COLLECTOR_EOF_MARKER_EN
                    state_d = S_TRAILER;
`else
                    state_d      = S_DONE;
                    frame_done_d = 1'b1;
`endif
                end
            end
`ifdef CORNER_COLLECTOR_EOF_MARKER_EN
            S_TRAILER: begin
                if (fv_rise) begin
                    pending_d = 1'b1;
                end
                if (qv_q && trl_q) begin
                    if (q_rdy) begin
                        state_d      = S_DONE;
                        frame_done_d = 1'b1;
                    end
                end else if (out_free && !grant) begin
                    q_d   = {CAM_ADDR, 2'b11, 13'd0, qv_cnt_d};
                    qv_d  = 1'b1;
                    trl_d = 1'b1;
                end
            end
`endif
            S_DONE: begin
                if (fv_rise) begin
                    pending_d = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // fv_prev resets high so a frame already in progress at reset never counts as a rise
    always_ff @(posedge c) begin
        if (rst) begin
            state_q      <= S_IDLE;
            fv_prev_q    <= 1'b1;
            pending_q    <= 1'b0;
            last_grant_q <= LGW'(LANES - 1);
            q_q          <= '0;
            qv_q         <= 1'b0;
            trl_q        <= 1'b0;
            qv_cnt_q     <= '0;
            drop_cnt_q   <= '0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            fv_prev_q    <= fv_prev_d;
            pending_q    <= pending_d;
            last_grant_q <= last_grant_d;
            q_q          <= q_d;
            qv_q         <= qv_d;
            trl_q        <= trl_d;
            qv_cnt_q     <= qv_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            frame_done_q <= frame_done_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    always_ff @(posedge c) begin
        for (int i = 0; i < LANES; i++) begin
            if (wr_en[i]) begin
                mem_q[i][wr_ptr_q[i][AW-1:0]] <= lane_word[i];
            end
        end
    end

    assign q          = q_q;
    assign qv         = qv_q;
    assign qv_cnt     = qv_cnt_q;
    assign drop_cnt   = drop_cnt_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ast_corner_collector.sv
// Directed self-checking bench for ast_corner_collector (LANES=4, FIFO_DEPTH=4, MAX_QV=8).
// Trailer checks follow CORNER_COLLECTOR_EOF_MARKER_EN when it is defined for the build.
module tb_ast_corner_collector;

    logic        c = 1'b0;
    logic        rst;
    logic        en;
    logic        fv;
    logic [3:0]  d_v;
    logic [31:0] d_score;
    logic [8:0]  d_col;
    logic [9:0]  d_row;
    logic        d_invalid;
    logic [31:0] q;
    logic        qv;
    logic        q_rdy;
    logic [15:0] qv_cnt;
    logic [15:0] drop_cnt;
    logic        frame_done;

    int checks   = 0;
    int failures = 0;
    int qvSeen;

    ast_corner_collector #(
        .LANES      (4),
        .FIFO_DEPTH (4),
        .MAX_QV     (8),
        .CAM_ADDR   (1'b0)
    ) dut (
        .c          (c),
        .rst        (rst),
        .en         (en),
        .fv         (fv),
        .d_v        (d_v),
        .d_score    (d_score),
        .d_col      (d_col),
        .d_row      (d_row),
        .d_invalid  (d_invalid),
        .q          (q),
        .qv         (qv),
        .q_rdy      (q_rdy),
        .qv_cnt     (qv_cnt),
        .drop_cnt   (drop_cnt),
        .frame_done (frame_done)
    );

    always #5 c = ~c;

    task automatic stepClk();
        @(posedge c);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] vld, input logic [8:0] col, input logic [9:0] row,
                                 input logic [31:0] scores, input logic inv);
        d_v       = vld;
        d_col     = col;
        d_row     = row;
        d_score   = scores;
        d_invalid = inv;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Drops fv with an empty pipeline and q_rdy high, then checks the drain / done sequence
    task automatic endFrame(input logic [15:0] cnt);
        fv = 1'b0;
        stepClk();
        checkOutput("drain_no_done", {31'd0, frame_done}, 32'd0);
`ifdef CORNER_COLLECTOR_EOF_MARKER_EN
        stepClk();
        checkOutput("trailer_wait_done", {31'd0, frame_done}, 32'd0);
        stepClk();
        checkOutput("trailer_qv", {31'd0, qv}, 32'd1);
        checkOutput("trailer_word", q, {16'h6000, cnt});
        stepClk();
        checkOutput("eof_frame_done", {31'd0, frame_done}, 32'd1);
        checkOutput("eof_qv_low", {31'd0, qv}, 32'd0);
`else
        stepClk();
        checkOutput("frame_done", {31'd0, frame_done}, 32'd1);
        checkOutput("no_trailer_qv", {31'd0, qv}, 32'd0);
        checkOutput("final_qv_cnt", {16'd0, qv_cnt}, {16'd0, cnt});
`endif
        stepClk();
        checkOutput("done_pulse_end", {31'd0, frame_done}, 32'd0);
    endtask

    initial begin
        rst   = 1'b1;
        en    = 1'b1;
        fv    = 1'b0;
        q_rdy = 1'b1;
        applyStimulus(4'b0000, 9'd0, 10'd0, 32'd0, 1'b0);
        stepClk();
        stepClk();
        checkOutput("rst_q", q, 32'd0);
        checkOutput("rst_qv", {31'd0, qv}, 32'd0);
        checkOutput("rst_qv_cnt", {16'd0, qv_cnt}, 32'd0);
        checkOutput("rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
        checkOutput("rst_frame_done", {31'd0, frame_done}, 32'd0);
        rst = 1'b0;
        stepClk();

        // Single detection on lane 2, preceded by a border-masked strobe
        fv = 1'b1;
        stepClk();
        applyStimulus(4'b0001, 9'd1, 10'd1, 32'h0000_00EE, 1'b1);
        stepClk();
        applyStimulus(4'b0100, 9'd5, 10'd9, 32'h0040_0000, 1'b0);
        stepClk();
        checkOutput("invalid_ignored", {31'd0, qv}, 32'd0);
        applyStimulus(4'b0000, 9'd0, 10'd0, 32'd0, 1'b0);
        stepClk();
        checkOutput("single_qv", {31'd0, qv}, 32'd1);
        checkOutput("single_word", q, 32'h0054_0940);
        stepClk();
        checkOutput("single_consumed", {31'd0, qv}, 32'd0);
        checkOutput("single_qv_cnt", {16'd0, qv_cnt}, 32'd1);
        endFrame(16'd1);

        // Reset restores last_grant so the first all-lane burst starts at lane 0
        rst = 1'b1;
        stepClk();
        rst = 1'b0;
        stepClk();
        fv = 1'b1;
        stepClk();
        applyStimulus(4'b1111, 9'd3, 10'd7, 32'h1312_1110, 1'b0);
        stepClk();
        applyStimulus(4'b0000, 9'd0, 10'd0, 32'd0, 1'b0);
        stepClk();
        checkOutput("burst1_lane0", q, 32'h003C_0710);
        stepClk();
        checkOutput("burst1_lane1", q, 32'h0038_0711);
        stepClk();
        checkOutput("burst1_lane2", q, 32'h0034_0712);
        stepClk();
        checkOutput("burst1_lane3", q, 32'h0030_0713);
        checkOutput("burst1_qv", {31'd0, qv}, 32'd1);
        applyStimulus(4'b0101, 9'd1, 10'd2, 32'hA3A2_A1A0, 1'b0);
        stepClk();
        applyStimulus(4'b0000, 9'd0, 10'd0, 32'd0, 1'b0);
        stepClk();
        checkOutput("burst2_lane0", q, 32'h001C_02A0);
        stepClk();
        checkOutput("burst2_lane2", q, 32'h0014_02A2);
        stepClk();
        checkOutput("burst2_idle", {31'd0, qv}, 32'd0);
        checkOutput("burst2_qv_cnt", {16'd0, qv_cnt}, 32'd6);
        endFrame(16'd6);

        // New frame: burst resumes after last grant (lane 2), so order is 3,0,1,2
        fv = 1'b1;
        stepClk();
        checkOutput("newframe_qv_cnt_clr", {16'd0, qv_cnt}, 32'd0);
        applyStimulus(4'b1111, 9'd0, 10'h3FF, 32'hF3F2_F1F0, 1'b0);
        stepClk();
        applyStimulus(4'b0000, 9'd0, 10'd0, 32'd0, 1'b0);
        stepClk();
        checkOutput("burst3_lane3", q, 32'h0003_FFF3);
        stepClk();
        checkOutput("burst3_lane0", q, 32'h000F_FFF0);
        stepClk();
        checkOutput("burst3_lane1", q, 32'h000B_FFF1);
        stepClk();
        checkOutput("burst3_lane2", q, 32'h0007_FFF2);
        stepClk();
        endFrame(16'd4);

        // Backpressure: 6 strobes on lane 0 with q_rdy low fill output reg + 4-deep FIFO, one drop
        fv = 1'b1;
        stepClk();
        q_rdy = 1'b0;
        for (int s = 1; s <= 6; s++) begin
            applyStimulus(4'b0001, 9'd2, 10'd1, 32'(s), 1'b0);
            stepClk();
        end
        applyStimulus(4'b0000, 9'd0, 10'd0, 32'd0, 1'b0);
        checkOutput("bp_drop_cnt", {16'd0, drop_cnt}, 32'd1);
        checkOutput("bp_qv_held", {31'd0, qv}, 32'd1);
        stepClk();
        stepClk();
        checkOutput("bp_q_held", q, 32'h002C_0101);
        q_rdy = 1'b1;
        for (int s = 2; s <= 5; s++) begin
            stepClk();
            checkOutput("bp_word", q, 32'h002C_0100 + 32'(s));
        end
        stepClk();
        checkOutput("bp_empty", {31'd0, qv}, 32'd0);
        checkOutput("bp_qv_cnt", {16'd0, qv_cnt}, 32'd5);
        endFrame(16'd5);

        // Cap: 10 detections against MAX_QV=8 give 8 words and 2 drops
        fv = 1'b1;
        stepClk();
        checkOutput("cap_drop_clr", {16'd0, drop_cnt}, 32'd0);
        qvSeen = 0;
        applyStimulus(4'b1111, 9'd6, 10'd3, 32'h5555_5555, 1'b0);
        stepClk();
        if (qv === 1'b1) qvSeen++;
        stepClk();
        if (qv === 1'b1) qvSeen++;
        applyStimulus(4'b0011, 9'd6, 10'd4, 32'h6666_6666, 1'b0);
        stepClk();
        if (qv === 1'b1) qvSeen++;
        applyStimulus(4'b0000, 9'd0, 10'd0, 32'd0, 1'b0);
        for (int n = 0; n < 20; n++) begin
            stepClk();
            if (qv === 1'b1) qvSeen++;
        end
        checkOutput("cap_words", 32'(qvSeen), 32'd8);
        checkOutput("cap_qv_cnt", {16'd0, qv_cnt}, 32'd8);
        checkOutput("cap_drop_cnt", {16'd0, drop_cnt}, 32'd2);
        endFrame(16'd8);

        // Reset mid-burst with three queued words, then a fresh frame must carry no stale data
        fv = 1'b1;
        stepClk();
        q_rdy = 1'b0;
        applyStimulus(4'b0111, 9'd7, 10'd8, 32'h0909_0909, 1'b0);
        stepClk();
        applyStimulus(4'b0000, 9'd0, 10'd0, 32'd0, 1'b0);
        stepClk();
        checkOutput("pre_rst_qv", {31'd0, qv}, 32'd1);
        rst = 1'b1;
        stepClk();
        checkOutput("midrst_qv", {31'd0, qv}, 32'd0);
        checkOutput("midrst_qv_cnt", {16'd0, qv_cnt}, 32'd0);
        checkOutput("midrst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
        rst   = 1'b0;
        q_rdy = 1'b1;
        stepClk();
        applyStimulus(4'b1111, 9'd7, 10'd8, 32'h0909_0909, 1'b0);
        stepClk();
        applyStimulus(4'b0000, 9'd0, 10'd0, 32'd0, 1'b0);
        stepClk();
        stepClk();
        checkOutput("idle_strobe_ignored", {31'd0, qv}, 32'd0);
        checkOutput("idle_strobe_no_drop", {16'd0, drop_cnt}, 32'd0);
        fv = 1'b0;
        stepClk();
        fv = 1'b1;
        stepClk();
        stepClk();
        stepClk();
        checkOutput("no_stale_qv", {31'd0, qv}, 32'd0);
        applyStimulus(4'b1000, 9'd4, 10'd5, 32'h7700_0000, 1'b0);
        stepClk();
        applyStimulus(4'b0000, 9'd0, 10'd0, 32'd0, 1'b0);
        stepClk();
        checkOutput("post_rst_word", q, 32'h0040_0577);
        checkOutput("post_rst_qv", {31'd0, qv}, 32'd1);
        stepClk();
        checkOutput("post_rst_drained", {31'd0, qv}, 32'd0);
        checkOutput("post_rst_qv_cnt", {16'd0, qv_cnt}, 32'd1);
        endFrame(16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
